// File: rtl/vfd_grid_scanner.sv
// vfd_grid_scanner: autonomous grid scanner for Itron-style grayscale VFDs.
// Define VFD_GCP_EN to generate gradient control pulses during shift-out.
module vfd_grid_scanner #(
  parameter int LANES     = 3,
  parameter int GRIDS     = 52,
  parameter int ROWS      = 39,
  parameter int ROW_BYTES = 78,
  parameter int PAD_BITS  = 2,
  parameter int PERIOD    = 3846,
  parameter int BLANK_CYC = 120,
  parameter int LAT_CYC   = 3,
  parameter int ADDR_W    = 13
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN,
  input  logic              BANK,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic              MEM_RE,
  input  logic [7:0]        MEM_BYTE,
  output logic [LANES-1:0]  SOUT,
  output logic              SCK,
  output logic              BLK,
  output logic              LAT,
  output logic              GCP,
  output logic [5:0]        GRID,
  output logic              BUSY
);

  localparam int NPIX  = ROWS * 6;
  localparam int NGRD  = NPIX + GRIDS;
  localparam int NBITS = NGRD + PAD_BITS;
  localparam int SEND  = BLANK_CYC + 2 * NBITS;
  localparam int TW    = $clog2(PERIOD);
  localparam int BW    = $clog2(NBITS + 1);
  localparam int BASE1 = ROWS * ROW_BYTES;
  localparam logic BPAR = 1'(BLANK_CYC % 2);

  if (SEND > PERIOD) begin : g_bad_period
    $error("BLANK_CYC + 2*NBITS exceeds PERIOD");
  end
  if (LANES < 1 || LANES > 4 || GRIDS % 2 != 0) begin : g_bad_cfg
    $error("LANES must be 1..4 and GRIDS even");
  end

  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_SHIFT, S_WAIT} state_t;

  state_t           st, st_n;
  logic [TW-1:0]    t, t_n;
  logic [BW-1:0]    b, fb;
  logic             ph, fetch, use_hi, pass;
  logic [2:0]       k, fk;
  logic [5:0]       sg, sg_n, grid_q, grid_n, gj;
  logic             bank_q, bank_n, sck_q;
  logic [LANES-1:0] pix_now, pix_q;
  logic             unused_bits;

  function automatic logic [1:0] byte_off(input logic [2:0] kk);
    case (kk)
      3'd0, 3'd2: return 2'd0;
      3'd1, 3'd3: return 2'd2;
      default:    return 2'd1;
    endcase
  endfunction

  assign unused_bits = ^MEM_BYTE;
  assign b  = BW'((t - TW'(BLANK_CYC)) >> 1);
  assign ph = t[0] ^ BPAR;
  assign k  = 3'(b % 6);
  assign fk = 3'(fb % 6);

  // pick the GRAM fetch one cycle ahead of each pixel bit's phase 0
  always_comb begin
    fetch = 1'b0;
    fb    = '0;
    if (st == S_BLANK && t == TW'(BLANK_CYC - 1)) fetch = 1'b1;
    if (st == S_SHIFT && ph && b < BW'(NPIX - 1)) begin
      fetch = 1'b1;
      fb    = b + 1'b1;
    end
  end

  // GRAM address: bank base + row + column pair + sub-pixel byte
  always_comb begin
    MEM_ADDR = '0;
    if (fetch)
      MEM_ADDR = ADDR_W'(int'(bank_q) * BASE1
                 + int'(fb / 6) * ROW_BYTES
                 + int'((sg - 6'd1) >> 1) * 3
                 + int'(byte_off(fk)));
  end

  // select nibble and mask the sub-pixels this grid does not own
  always_comb begin
    use_hi  = (k == 3'd0) || (k == 3'd3) || (k == 3'd4);
    pass    = k[0] ^ sg[0];
    pix_now = '0;
    if (pass)
      pix_now = use_hi ? MEM_BYTE[2*LANES-1:LANES]
                       : MEM_BYTE[LANES-1:0];
  end

  // serial data: pixel field, grid field, then zero padding
  always_comb begin
    SOUT = '0;
    gj   = 6'(b - BW'(NPIX) + 1);
    if (st == S_SHIFT) begin
      if (b < BW'(NPIX)) begin
        SOUT = ph ? pix_q : pix_now;
      end else if (b < BW'(NGRD)) begin
        if (gj == sg || gj == sg + 6'd1) SOUT = '1;
      end
    end
  end

  // next-state: slot timing, grid advance and bank latch
  always_comb begin
    st_n   = st;
    t_n    = t;
    sg_n   = sg;
    grid_n = grid_q;
    bank_n = bank_q;
    unique case (st)
      S_IDLE: begin
        if (EN) begin
          st_n = S_BLANK;
          if (sg == 6'd1) bank_n = BANK;
        end
      end
      S_BLANK: begin
        t_n = t + 1'b1;
        if (t == TW'(BLANK_CYC - 1)) st_n = S_SHIFT;
      end
      default: begin
        t_n = t + 1'b1;
        if (st == S_SHIFT && t == TW'(SEND - 1)) st_n = S_WAIT;
        if (t == TW'(PERIOD - 1)) begin
          t_n = '0;
          if (EN) begin
            st_n   = S_BLANK;
            grid_n = sg;
            sg_n   = (sg == 6'(GRIDS)) ? 6'd1 : sg + 6'd1;
            if (sg == 6'(GRIDS)) bank_n = BANK;
          end else begin
            st_n   = S_IDLE;
            grid_n = '0;
          end
        end
      end
    endcase
  end

  // state, counters and registered SCK / held pixel
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      st     <= S_IDLE;
      t      <= '0;
      sg     <= 6'd1;
      grid_q <= '0;
      bank_q <= 1'b0;
      sck_q  <= 1'b0;
      pix_q  <= '0;
    end else begin
      st     <= st_n;
      t      <= t_n;
      sg     <= sg_n;
      grid_q <= grid_n;
      bank_q <= bank_n;
      sck_q  <= (st_n == S_SHIFT) && (t_n[0] ^ BPAR);
      if (st == S_SHIFT && !ph) pix_q <= pix_now;
    end
  end

  assign SCK    = sck_q;
  assign MEM_RE = fetch;
  assign BLK    = (st == S_IDLE) || (st == S_BLANK);
  assign LAT    = (st == S_BLANK) && (t < TW'(LAT_CYC));
  assign BUSY   = (st != S_IDLE);
  assign GRID   = grid_q;

`ifdef VFD_GCP_EN
  localparam int GCP_RAW = (1 << LANES) - 2;
  localparam int GCP_N   = (GCP_RAW > 6) ? 6 : GCP_RAW;

  logic       gcp_hit;
  logic [1:0] gcp_cnt;

  function automatic int gcp_ref(input int i);
    case (i)
      0:       return 72;
      1:       return 144;
      2:       return 192;
      3:       return 216;
      4:       return 240;
      default: return 256;
    endcase
  endfunction

  // flag phase 0 of any scaled pulse bit
  always_comb begin
    gcp_hit = 1'b0;
    for (int i = 0; i < GCP_N; i++)
      if (st == S_SHIFT && !ph &&
          int'(b) == gcp_ref(i) * NBITS / 288)
        gcp_hit = 1'b1;
  end

  // stretch each pulse over the two following cycles
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                gcp_cnt <= 2'd0;
    else if (gcp_hit)       gcp_cnt <= 2'd2;
    else if (gcp_cnt != 0)  gcp_cnt <= gcp_cnt - 2'd1;
  end

  assign GCP = gcp_hit || (gcp_cnt != 2'd0);
`else
  assign GCP = 1'b0;
`endif

endmodule
